// File: rtl/ultrasonic_ranger.sv
// -----------------------------------------------------------------------------
// ultrasonic_ranger
//
// Front-end for the obstacle detector. Fires two ultrasonic range sensors
// (left, right) in strict alternation. Each echo pulse is timed in clock
// cycles and compared against a near threshold. Each channel has a
// two-sample agreement filter whose output is the obstacle flag consumed
// downstream. Every completed measurement is also exported as a raw sample
// strobe for debug.
//
// Parameters
//   W             width of the echo counter and of sample_width
//   TRIG_CYCLES   trigger pulse length, cycles
//   GAP_CYCLES    quiet time before each trigger, cycles
//   WAIT_TIMEOUT  longest wait for an echo rising edge, cycles
//   MAX_ECHO      saturation value of the echo width (must be < 2^W)
//   NEAR_CYCLES   a width strictly below this counts as "near"
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   echo_left      asynchronous echo input, left sensor
//   echo_right     asynchronous echo input, right sensor
//   trig_left      trigger output, left sensor
//   trig_right     trigger output, right sensor
//   sensor_left    filtered obstacle flag, left
//   sensor_right   filtered obstacle flag, right
//   sample_valid   one-cycle strobe for a completed measurement
//   sample_ch      channel of the last sample (0 = left, 1 = right)
//   sample_width   measured echo width in cycles, saturated at MAX_ECHO
//   sample_timeout last sample ended because no echo edge arrived
// -----------------------------------------------------------------------------
module ultrasonic_ranger #(
   parameter int W            = 16,
   parameter int TRIG_CYCLES  = 100,
   parameter int GAP_CYCLES   = 5000,
   parameter int WAIT_TIMEOUT = 2000,
   parameter int MAX_ECHO     = 60000,
   parameter int NEAR_CYCLES  = 3000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         echo_left,
   input  logic         echo_right,
   output logic         trig_left,
   output logic         trig_right,
   output logic         sensor_left,
   output logic         sensor_right,
   output logic         sample_valid,
   output logic         sample_ch,
   output logic [W-1:0] sample_width,
   output logic         sample_timeout
);

   // One shared counter times the gap, the trigger, the echo wait and the
   // echo width, so it must be wide enough for the largest of them.
   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int CNT_TOP = max_of(max_of(GAP_CYCLES, TRIG_CYCLES),
                                   max_of(WAIT_TIMEOUT, MAX_ECHO));
   localparam int CW      = $clog2(CNT_TOP + 1);

   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_SAT   = CW'(MAX_ECHO);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [W-1:0]  MAX_W     = W'(MAX_ECHO);

   typedef enum logic [1:0] {
      S_GAP,
      S_TRIG,
      S_WAIT,
      S_MEAS
   } state_t;

   // ---------------------------------------------------------------------
   // Echo conditioning: 2-flop synchronizer plus a previous-value register
   // per channel. Both edges see the same two-cycle delay, so the measured
   // width equals the pulse width.
   // ---------------------------------------------------------------------
   logic [1:0] echo_raw;
   logic [1:0] level_vec;
   logic [1:0] rise_vec;
   logic [1:0] fall_vec;

   assign echo_raw = {echo_right, echo_left};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_reg;
         logic s_reg;
         logic prev_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               meta_reg <= 1'b0;
               s_reg    <= 1'b0;
               prev_reg <= 1'b0;
            end else begin
               meta_reg <= echo_raw[gi];
               s_reg    <= meta_reg;
               prev_reg <= s_reg;
            end
         end

         assign level_vec[gi] = s_reg;
         assign rise_vec[gi]  = s_reg & ~prev_reg;
         assign fall_vec[gi]  = ~s_reg & prev_reg;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Measurement sequencer
   // ---------------------------------------------------------------------
   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            ch_reg, ch_next;

   logic            echo_level;
   logic            echo_rise;
   logic            echo_fall;

   logic            done;
   logic [W-1:0]    done_width;
   logic            done_timeout;
   logic            near;

   // Only the active channel is ever looked at.
   assign echo_level = level_vec[ch_reg];
   assign echo_rise  = rise_vec[ch_reg];
   assign echo_fall  = fall_vec[ch_reg];

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ch_next      = ch_reg;
      done         = 1'b0;
      done_width   = '0;
      done_timeout = 1'b0;

      case (state_reg)
         S_GAP: begin
            if (cnt_reg == GAP_LAST) begin
               state_next = S_TRIG;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end

         S_TRIG: begin
            if (cnt_reg == TRIG_LAST) begin
               state_next = S_WAIT;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end

         S_WAIT: begin
            // The previous-value register keeps tracking outside this
            // state, so an echo that is already high on entry is not an
            // edge.
            if (echo_rise) begin
               state_next = S_MEAS;
               cnt_next   = CNT_ONE;
            end else if (cnt_reg == WAIT_LAST) begin
               done         = 1'b1;
               done_width   = MAX_W;
               done_timeout = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end

         S_MEAS: begin
            // Saturation is checked first; a pulse of exactly MAX_ECHO
            // yields the same width either way.
            if (cnt_reg == CNT_SAT) begin
               done       = 1'b1;
               done_width = MAX_W;
            end else if (echo_fall) begin
               done       = 1'b1;
               done_width = W'(cnt_reg);
            end else if (echo_level) begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end

         default: begin
            state_next = S_GAP;
            cnt_next   = '0;
         end
      endcase

      // Every completed measurement hands over to the other channel.
      if (done) begin
         state_next = S_GAP;
         cnt_next   = '0;
         ch_next    = ~ch_reg;
      end
   end

   // Triggers are registered from the next-state decode so they come
   // straight off flops and line up exactly with the TRIG state.
   logic         trig_left_reg;
   logic         trig_right_reg;
   logic         sample_valid_reg;
   logic         sample_ch_reg;
   logic [W-1:0] sample_width_reg;
   logic         sample_timeout_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg          <= S_GAP;
         cnt_reg            <= '0;
         ch_reg             <= 1'b0;
         trig_left_reg      <= 1'b0;
         trig_right_reg     <= 1'b0;
         sample_valid_reg   <= 1'b0;
         sample_ch_reg      <= 1'b0;
         sample_width_reg   <= '0;
         sample_timeout_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         ch_reg           <= ch_next;
         trig_left_reg    <= (state_next == S_TRIG) && !ch_next;
         trig_right_reg   <= (state_next == S_TRIG) &&  ch_next;
         sample_valid_reg <= done;
         if (done) begin
            sample_ch_reg      <= ch_reg;
            sample_width_reg   <= done_width;
            sample_timeout_reg <= done_timeout;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Two-sample agreement filter, one per channel. The flag only moves when
   // two consecutive raw results for that channel agree and differ from it.
   // ---------------------------------------------------------------------
   assign near = (32'(done_width) < 32'(NEAR_CYCLES));

   logic [1:0] sensor_vec;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_filter
         logic hist_reg;
         logic sensor_reg;
         logic hit;

         assign hit = done && (ch_reg == 1'(gi));

         always_ff @(posedge clk) begin
            if (reset) begin
               hist_reg   <= 1'b0;
               sensor_reg <= 1'b0;
            end else if (hit) begin
               if ((near == hist_reg) && (near != sensor_reg)) begin
                  sensor_reg <= near;
               end
               hist_reg <= near;
            end
         end

         assign sensor_vec[gi] = sensor_reg;
      end
   endgenerate

   assign trig_left      = trig_left_reg;
   assign trig_right     = trig_right_reg;
   assign sensor_left    = sensor_vec[0];
   assign sensor_right   = sensor_vec[1];
   assign sample_valid   = sample_valid_reg;
   assign sample_ch      = sample_ch_reg;
   assign sample_width   = sample_width_reg;
   assign sample_timeout = sample_timeout_reg;

endmodule
